// File: rtl/cpu_1_ocimem_pkg.sv
// cpu_1_ocimem_pkg: shared state encoding, jdo field positions and control-register layout
package cpu_1_ocimem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RD_ISSUE, ST_RD_CAPT, ST_WR_ISSUE} jtag_state_t;
    localparam int RAM_DEPTH   = 256;
    localparam int JDO_ADDR_HI = 33;
    localparam int JDO_ADDR_LO = 26;
    localparam int JDO_READ    = 25;
    localparam int JDO_CLEAR   = 24;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    localparam int CTRL_READY  = 0;
    localparam int CTRL_ERROR  = 1;
endpackage

// File: rtl/cpu_1_ocimem_ram.sv
// cpu_1_ocimem_ram: single-port RAM with byte-lane writes and a registered read port
module cpu_1_ocimem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        q
);
    logic [DATA_W-1:0] mem [DEPTH];
    // write the enabled lanes and register the addressed word (old data on a write)
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++)
            if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        q <= mem[addr];
    end
endmodule

// File: rtl/cpu_1_jtag_ocimem.sv
// cpu_1_jtag_ocimem: on-chip debug memory shared between a JTAG monitor and a CPU slave port
module cpu_1_jtag_ocimem #(
    parameter int RAM_DEPTH = cpu_1_ocimem_pkg::RAM_DEPTH,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [37:0]         jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic [8:0]          address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                debugaccess,
    output logic [DATA_W-1:0]   readdata,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   MonDReg,
    output logic [7:0]          MonAReg,
    output logic                monitor_ready,
    output logic                monitor_error
);
    import cpu_1_ocimem_pkg::*;
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int BW = DATA_W / 8;
    jtag_state_t state, state_nxt;
    logic rd_pend, wr_pend, rd_phase, rd_ctl;
    logic jtag_own, cpu_ram, cpu_ctl, cpu_stall, strobe, busy, accept, issue, clr, set_rdy, set_err;
    logic [DATA_W-1:0] ram_q, ram_wdata, ctl_q, rd_hold;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be;
    logic ram_we;
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign jtag_own  = (state == ST_RD_ISSUE) || (state == ST_WR_ISSUE);
    assign cpu_ram   = chipselect && !address[8];
    assign cpu_ctl   = chipselect && address[8];
    assign cpu_stall = cpu_ram && (read || write) && jtag_own;
    assign strobe    = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
    assign busy      = (state != ST_IDLE) || rd_pend || wr_pend;
    assign accept    = strobe && !busy;
    assign issue     = (state == ST_IDLE) && (rd_pend || wr_pend) && !rd_phase;
    assign clr       = accept && take_action_ocimem_a && jdo[JDO_CLEAR];
    assign set_rdy   = cpu_ctl && write && writedata[CTRL_READY];
    assign set_err   = cpu_ctl && write && writedata[CTRL_ERROR];
    assign ram_addr  = jtag_own ? MonAReg[AW-1:0] : address[AW-1:0];
    assign ram_we    = reset_n && (jtag_own ? (state == ST_WR_ISSUE) : (cpu_ram && write && debugaccess));
    assign ram_be    = jtag_own ? {BW{1'b1}} : byteenable;
    assign ram_wdata = jtag_own ? MonDReg : writedata;
    assign readdata  = rd_phase ? (rd_ctl ? ctl_q : ram_q) : rd_hold;
    assign waitrequest = reset_n && chipselect && (cpu_stall || (read && !rd_phase));

    cpu_1_ocimem_ram #(.DEPTH(RAM_DEPTH), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // JTAG access state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // leave IDLE only for a queued request while no CPU read is in its data phase
    always_comb begin
        state_nxt = ST_IDLE;
        state_nxt = issue ? (rd_pend ? ST_RD_ISSUE : ST_WR_ISSUE) :
                    (state == ST_RD_ISSUE) ? ST_RD_CAPT : ST_IDLE;
    end

    // JTAG monitor registers, request queue and sticky status (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonAReg       <= '0;
            MonDReg       <= '0;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (accept && take_action_ocimem_a) begin
                MonAReg <= jdo[JDO_ADDR_HI:JDO_ADDR_LO];
                rd_pend <= jdo[JDO_READ];
            end else if (accept && take_no_action_ocimem_a) begin
                MonAReg <= MonAReg + 8'd1;
                rd_pend <= 1'b1;
            end else if (accept) begin
                MonDReg <= jdo[JDO_DATA_HI:JDO_DATA_LO];
                wr_pend <= 1'b1;
            end else if (issue) begin
                rd_pend <= 1'b0;
                wr_pend <= 1'b0;
            end
            if (state == ST_WR_ISSUE) MonAReg <= MonAReg + 8'd1;
            if (state == ST_RD_CAPT) MonDReg <= ram_q;
            monitor_ready <= set_rdy || (monitor_ready && !clr);
            monitor_error <= set_err || (strobe && busy) || (monitor_error && !clr);
        end
    end

    // CPU read phase tracking; readdata holds its last value outside a data phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_phase <= 1'b0;
            rd_ctl   <= 1'b0;
            ctl_q    <= '0;
            rd_hold  <= '0;
        end else begin
            rd_phase <= chipselect && read && !rd_phase && !cpu_stall;
            rd_ctl   <= address[8];
            ctl_q    <= '0;
            ctl_q[CTRL_READY] <= monitor_ready;
            ctl_q[CTRL_ERROR] <= monitor_error;
            rd_hold  <= readdata;
        end
    end
endmodule

// File: tb/tb_cpu_1_jtag_ocimem.sv
// tb_cpu_1_jtag_ocimem: directed self-checking bench for the JTAG/CPU debug memory
module tb_cpu_1_jtag_ocimem;
    import cpu_1_ocimem_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0, take_next = 1'b0, take_b = 1'b0;
    logic [8:0]  address = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, debugaccess = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata, MonDReg;
    logic [7:0]  MonAReg;
    logic        waitrequest, monitor_ready, monitor_error;
    int checks = 0;
    int errors = 0;

    cpu_1_jtag_ocimem dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_next),
        .take_action_ocimem_b    (take_b),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cpu();
        chipselect = 0; read = 0; write = 0; address = '0;
        writedata = '0; byteenable = '0; debugaccess = 0;
    endtask

    task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
        chipselect = 1; write = 1; address = a; writedata = d; byteenable = be; debugaccess = dbg;
        #1 chk("cpu_wr_wait", waitrequest, 0);
        tick();
        idle_cpu();
    endtask

    task automatic cpu_rd(input string tag, input logic [8:0] a, input logic [31:0] exp);
        chipselect = 1; read = 1; address = a;
        #1 chk({tag, "_wait1"}, waitrequest, 1);
        tick();
        chk({tag, "_wait2"}, waitrequest, 0);
        chk(tag, readdata, exp);
        tick();
        idle_cpu();
    endtask

    task automatic jtag_a(input logic [7:0] a, input logic rd, input logic clr);
        jdo = '0; jdo[33:26] = a; jdo[25] = rd; jdo[24] = clr; take_a = 1;
        tick();
        take_a = 0; jdo = '0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0; jdo[34:3] = d; take_b = 1;
        tick();
        take_b = 0; jdo = '0;
    endtask

    initial begin
        // reset, with a CPU read pending to show waitrequest is held low
        #2 reset_n = 0; chipselect = 1; read = 1;
        #1;
        chk("rst_wait", waitrequest, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_areg", MonAReg, 0);
        chk("rst_dreg", MonDReg, 0);
        chk("rst_ready", monitor_ready, 0);
        chk("rst_error", monitor_error, 0);
        idle_cpu();
        tick(); tick();
        reset_n = 1;
        tick();

        // JTAG write of DEADBEEF at 0x10, then CPU read-back
        jtag_a(8'h10, 0, 0);
        chk("areg_load", MonAReg, 8'h10);
        jtag_b(32'hDEADBEEF);
        chk("dreg_load", MonDReg, 32'hDEADBEEF);
        tick(); tick();
        chk("areg_after_wr", MonAReg, 8'h11);
        cpu_rd("rd_10", 9'h010, 32'hDEADBEEF);
        chk("no_error", monitor_error, 0);
        read = 1; address = 9'h010;
        tick();
        chk("cs0_wait", waitrequest, 0);
        chk("cs0_hold", readdata, 32'hDEADBEEF);
        idle_cpu();

        // JTAG read at 0xFF, then read-next wraps to 0x00
        cpu_wr(9'h0FF, 32'hCAFEF00D, 4'hF, 1);
        cpu_wr(9'h000, 32'h0BADC0DE, 4'hF, 1);
        jtag_a(8'hFF, 1, 0);
        tick(); tick(); tick();
        chk("rd_ff", MonDReg, 32'hCAFEF00D);
        chk("areg_ff", MonAReg, 8'hFF);
        take_next = 1;
        tick();
        take_next = 0;
        chk("areg_wrap", MonAReg, 8'h00);
        tick(); tick(); tick();
        chk("rd_00", MonDReg, 32'h0BADC0DE);

        // byte-lane write and debugaccess qualification
        cpu_wr(9'h005, 32'hAAAAAAAA, 4'hF, 1);
        cpu_wr(9'h005, 32'h12345678, 4'b0011, 1);
        cpu_rd("rd_5_be", 9'h005, 32'hAAAA5678);
        cpu_wr(9'h005, 32'h12345678, 4'hF, 0);
        cpu_rd("rd_5_nodbg", 9'h005, 32'hAAAA5678);

        // JTAG write queued during a CPU read waits for its data phase
        jtag_a(8'h20, 0, 0);
        chipselect = 1; read = 1; address = 9'h010;
        jdo = '0; jdo[34:3] = 32'h11223344; take_b = 1;
        #1 chk("ovl_wait_a", waitrequest, 1);
        tick();
        take_b = 0; jdo = '0;
        chk("ovl_wait_b", waitrequest, 0);
        chk("ovl_data_b", readdata, 32'hDEADBEEF);
        tick();
        idle_cpu();
        tick();
        chipselect = 1; write = 1; address = 9'h030; writedata = 32'h55; byteenable = 4'hF; debugaccess = 1;
        #1 chk("wr_issue_stall", waitrequest, 1);
        tick();
        chk("wr_after_stall", waitrequest, 0);
        tick();
        idle_cpu();
        chk("areg_21", MonAReg, 8'h21);
        cpu_rd("rd_20", 9'h020, 32'h11223344);
        cpu_rd("rd_30", 9'h030, 32'h00000055);

        // status flags: CPU set, JTAG clear, set-wins, strobe while busy
        cpu_wr(9'h100, 32'h3, 4'hF, 0);
        chk("set_ready", monitor_ready, 1);
        chk("set_error", monitor_error, 1);
        jtag_a(8'h00, 0, 1);
        chk("clr_ready", monitor_ready, 0);
        chk("clr_error", monitor_error, 0);
        chipselect = 1; write = 1; address = 9'h100; writedata = 32'h3; byteenable = 4'hF;
        jdo = '0; jdo[33:26] = 8'h10; jdo[24] = 1; take_a = 1;
        tick();
        take_a = 0; jdo = '0;
        idle_cpu();
        chk("setwin_ready", monitor_ready, 1);
        chk("setwin_error", monitor_error, 1);
        jtag_a(8'h10, 1, 1);
        chk("clr2_error", monitor_error, 0);
        tick(); tick();
        take_next = 1;
        tick();
        take_next = 0;
        chk("busy_error", monitor_error, 1);
        chk("busy_ready", monitor_ready, 0);
        chk("busy_areg", MonAReg, 8'h10);
        chk("busy_dreg", MonDReg, 32'hDEADBEEF);
        cpu_rd("ctl_rd", 9'h100, 32'h2);

        // reset during WR_ISSUE aborts the write
        cpu_wr(9'h040, 32'h77777777, 4'hF, 1);
        jtag_a(8'h40, 0, 0);
        jtag_b(32'h99999999);
        tick();
        chk("pre_rst_state", dut.state, ST_WR_ISSUE);
        chipselect = 1; read = 1; address = 9'h040;
        reset_n = 0;
        #1;
        chk("mrst_state", dut.state, ST_IDLE);
        chk("mrst_wait", waitrequest, 0);
        chk("mrst_readdata", readdata, 0);
        chk("mrst_areg", MonAReg, 0);
        chk("mrst_dreg", MonDReg, 0);
        chk("mrst_ready", monitor_ready, 0);
        chk("mrst_error", monitor_error, 0);
        idle_cpu();
        tick(); tick();
        reset_n = 1;
        tick();
        cpu_rd("rd_40", 9'h040, 32'h77777777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
